alarm_ctrl: RTL

//  Alarm controller downstream of the clock-enabled minute/hour counter chain.

---
 rtl/alarm_if.sv | 46 ++++
 rtl/alarm_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alarm_if.sv
// ---------------------------------------------------------------------------
// alarm_if
// Signal bundle between the time-keeping / user-input side and the alarm
// controller.
//   master : drives the time-of-day, the alarm-load bus and the user
//            controls, and observes the controller outputs
//            (testbench or system top).
//   slave  : alarm_ctrl side.
// Signals
//   tick_sec   1-cycle enable, once per second
//   cur_min    current minute 0..59        cur_hr    current hour 0..23
//   alm_min_d  alarm minute to load        alm_hr_d  alarm hour to load
//   alm_ld     load strobe                 alm_en    alarm enable switch (level)
//   snooze     snooze button pulse         stop      stop button pulse
//   alm_min_q  stored alarm minute         alm_hr_q  stored alarm hour
//   state      00 IDLE, 01 ARMED, 10 RINGING, 11 SNOOZE
//   buzz       buzzer drive                alm_err   rejected-load pulse
// ---------------------------------------------------------------------------
interface alarm_if;
    logic       tick_sec;
    logic [5:0] cur_min;
    logic [4:0] cur_hr;
    logic [5:0] alm_min_d;
    logic [4:0] alm_hr_d;
    logic       alm_ld;
    logic       alm_en;
    logic       snooze;
    logic       stop;
    logic [5:0] alm_min_q;
    logic [4:0] alm_hr_q;
    logic [1:0] state;
    logic       buzz;
    logic       alm_err;

    modport master (
        output tick_sec, cur_min, cur_hr, alm_min_d, alm_hr_d,
               alm_ld, alm_en, snooze, stop,
        input  alm_min_q, alm_hr_q, state, buzz, alm_err
    );

    modport slave (
        input  tick_sec, cur_min, cur_hr, alm_min_d, alm_hr_d,
               alm_ld, alm_en, snooze, stop,
        output alm_min_q, alm_hr_q, state, buzz, alm_err
    );
endinterface

// File: rtl/alarm_ctrl.sv
// ---------------------------------------------------------------------------
// alarm_ctrl
// Alarm controller sitting downstream of the minute/hour counter chain.
// Stores the alarm time, compares it with the running time-of-day and
// sequences IDLE / ARMED / RINGING / SNOOZE on the 1 Hz tick_sec enable.
// Ports
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   alarm_if.slave (time inputs, alarm load, buttons, outputs)
// Parameters
//   RING_SECS    seconds RINGING lasts before returning to ARMED (>=1)
//   SNOOZE_SECS  seconds spent in SNOOZE before ringing again (>=1)
//   CW           second-counter width, holds max(RING_SECS,SNOOZE_SECS)-1
// Build option
//   ALARM_BEEP_EN  when defined, buzz toggles on every tick_sec while
//                  RINGING (starting at 1); otherwise buzz is steady 1.
// ---------------------------------------------------------------------------
module alarm_ctrl #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int CW          = 9
) (
    input  logic   clk,
    input  logic   rst,
    alarm_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_RINGING = 2'b10,
        ST_SNOOZE  = 2'b11
    } state_t;

    localparam logic [CW-1:0] RING_LAST   = CW'(RING_SECS - 1);
    localparam logic [CW-1:0] SNOOZE_LAST = CW'(SNOOZE_SECS - 1);

    // A requested alarm time is accepted only if it is a real time of day.
    function automatic logic time_valid(input logic [5:0] m, input logic [4:0] h);
        return (m <= 6'd59) && (h <= 5'd23);
    endfunction

    state_t        state_q,    state_d;
    logic [CW-1:0] ring_cnt_q, ring_cnt_d;
    logic [CW-1:0] snz_cnt_q,  snz_cnt_d;
    logic [5:0]    alm_min_q,  alm_min_d;
    logic [4:0]    alm_hr_q,   alm_hr_d;
    logic          match_d_q,  match_d_d;
    logic          buzz_q,     buzz_d;
    logic          alm_err_q,  alm_err_d;
    logic          match;
    logic          trigger;

    // Alarm-time register update and range check of load requests.
    always_comb begin
        alm_min_d = alm_min_q;
        alm_hr_d  = alm_hr_q;
        alm_err_d = 1'b0;
        if (bus.alm_ld) begin
            if (time_valid(bus.alm_min_d, bus.alm_hr_d)) begin
                alm_min_d = bus.alm_min_d;
                alm_hr_d  = bus.alm_hr_d;
            end else begin
                alm_err_d = 1'b1;
            end
        end else begin
            alm_err_d = 1'b0;
        end
    end

    // Time comparison; only the first cycle of a match fires, so a stopped
    // alarm stays quiet for the rest of that minute.
    always_comb begin
        match     = (bus.cur_min == alm_min_q) && (bus.cur_hr == alm_hr_q);
        match_d_d = match;
        trigger   = match && !match_d_q;
    end

    // Next-state and second-counter logic; ~alm_en > stop > snooze > trigger/timeout.
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.alm_en) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (!bus.alm_en) begin
                    state_d = ST_IDLE;
                end else if (trigger) begin
                    state_d    = ST_RINGING;
                    ring_cnt_d = {CW{1'b0}};
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_RINGING: begin
                if (!bus.alm_en) begin
                    state_d = ST_IDLE;
                end else if (bus.stop) begin
                    state_d = ST_ARMED;
                end else if (bus.snooze) begin
                    state_d   = ST_SNOOZE;
                    snz_cnt_d = {CW{1'b0}};
                end else if (bus.tick_sec) begin
                    if (ring_cnt_q == RING_LAST) begin
                        state_d = ST_ARMED;
                    end else begin
                        ring_cnt_d = ring_cnt_q + CW'(1);
                    end
                end else begin
                    state_d = ST_RINGING;
                end
            end
            ST_SNOOZE: begin
                if (!bus.alm_en) begin
                    state_d = ST_IDLE;
                end else if (bus.stop) begin
                    state_d = ST_ARMED;
                end else if (bus.tick_sec) begin
                    if (snz_cnt_q == SNOOZE_LAST) begin
                        state_d    = ST_RINGING;
                        ring_cnt_d = {CW{1'b0}};
                    end else begin
                        snz_cnt_d = snz_cnt_q + CW'(1);
                    end
                end else begin
                    state_d = ST_SNOOZE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                ring_cnt_d = {CW{1'b0}};
                snz_cnt_d  = {CW{1'b0}};
            end
        endcase
    end

    // Buzzer drive, derived from the next state so it rises together with RINGING.
    always_comb begin
        buzz_d = 1'b0;
`ifdef ALARM_BEEP_EN
        if (state_d == ST_RINGING) begin
            if (state_q != ST_RINGING) begin
                buzz_d = 1'b1;
            end else if (bus.tick_sec) begin
                buzz_d = !buzz_q;
            end else begin
                buzz_d = buzz_q;
            end
        end else begin
            buzz_d = 1'b0;
        end
`else
        buzz_d = (state_d == ST_RINGING);
`endif
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ring_cnt_q <= {CW{1'b0}};
            snz_cnt_q  <= {CW{1'b0}};
            alm_min_q  <= 6'd0;
            alm_hr_q   <= 5'd0;
            match_d_q  <= 1'b0;
            buzz_q     <= 1'b0;
            alm_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            alm_min_q  <= alm_min_d;
            alm_hr_q   <= alm_hr_d;
            match_d_q  <= match_d_d;
            buzz_q     <= buzz_d;
            alm_err_q  <= alm_err_d;
        end
    end

    assign bus.alm_min_q = alm_min_q;
    assign bus.alm_hr_q  = alm_hr_q;
    assign bus.state     = state_q;
    assign bus.buzz      = buzz_q;
    assign bus.alm_err   = alm_err_q;

endmodule
